// File: rtl/vga_sync_gen.sv
// VGA timing generator: free-running h/v scan counters (stage 0) feeding a
// registered colour/sync/strobe stage (stage 1) that lags x_o/y_o by one cycle.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CW       = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [5:0]    rgb_i,
  output logic [CW-1:0] x_o,
  output logic [CW-1:0] y_o,
  output logic          de_o,
  output logic [1:0]    r_o,
  output logic [1:0]    g_o,
  output logic [1:0]    b_o,
  output logic          hs_o,
  output logic          vs_o,
  output logic          next_vertical_o,
  output logic          next_frame_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0: scan counters
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;

  // Stage 1: registered outputs, all describing the same pixel
  logic [5:0] rgb_q, rgb_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       nv_q, nv_d;
  logic       nf_q, nf_d;

  logic h_wrap, v_wrap;
  logic h_act, v_act;
  logic h_sync, v_sync;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);
  assign h_act  = (h_q < H_ACT_END);
  assign v_act  = (v_q < V_ACT_END);
  assign h_sync = (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign v_sync = (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

  // The renderer answers rgb_i combinationally for the x_o/y_o it sees;
  // it is only captured while de_o is high, so blanking is always black.
  assign de_o = h_act && v_act && !rst_i;

  always_comb begin
    h_d  = h_wrap ? '0 : h_q + CW'(1);
    v_d  = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + CW'(1);
    end
    rgb_d = de_o ? rgb_i : 6'd0;
    hs_d  = h_sync ? HS_POL : ~HS_POL;
    vs_d  = v_sync ? VS_POL : ~VS_POL;
    nv_d  = h_wrap;
    nf_d  = h_wrap && v_wrap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_q   <= '0;
      v_q   <= '0;
      rgb_q <= 6'd0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      nv_q  <= 1'b0;
      nf_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      nv_q  <= nv_d;
      nf_q  <= nf_d;
    end
  end

  assign x_o             = h_q;
  assign y_o             = v_q;
  assign r_o             = rgb_q[5:4];
  assign g_o             = rgb_q[3:2];
  assign b_o             = rgb_q[1:0];
  assign hs_o            = hs_q;
  assign vs_o            = vs_q;
  assign next_vertical_o = nv_q;
  assign next_frame_o    = nf_q;

endmodule
